// File: rtl/sls_serial_adder_v_if.sv
// Operand/result bundle for the bit-serial adder.
//   start, a, b, cin : request and operands, driven by the master
//   busy, done       : status, driven by the adder
//   sum, cout        : registered result, driven by the adder
interface sls_serial_adder_v_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/sls_serial_adder_v.sv
// Bit-serial N-bit adder: loads a, b and cin on start, then adds one bit
// per clock (LSB first) through a single full-adder cell with a carry
// flop between slices. Presents sum/cout with a one-cycle done pulse.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of sls_serial_adder_v_if (start/a/b/cin in,
//             busy/done/sum/cout out)
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | waiting for start; operands loaded on accept
// ST_SHIFT | one bit slice added per clock, N clocks
// ST_DONE  | result valid, done high for one cycle

module sls_full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum_bit,
  output logic cout_bit
);
  assign sum_bit  = x ^ y ^ cin;
  assign cout_bit = (x & y) | (cin & (x ^ y));
endmodule

module sls_serial_adder_v #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sls_serial_adder_v_if.slave  bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_sh_q, a_sh_d;
  logic [N-1:0]  b_sh_q, b_sh_d;
  // Holds the N-1 low result bits; the MSB comes straight from the
  // adder on the completing edge.
  logic [N-2:0]  psum_q, psum_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;

  logic sum_bit;
  logic cout_bit;

  sls_full_adder u_fa (
    .x        (a_sh_q[0]),
    .y        (b_sh_q[0]),
    .cin      (carry_q),
    .sum_bit  (sum_bit),
    .cout_bit (cout_bit)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    count_d = count_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          count_d = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        // Shift right with the new bit entering at the top.
        psum_d  = (N-1)'({sum_bit, psum_q} >> 1);
        carry_d = cout_bit;
        count_d = count_q + CW'(1);
        if (count_q == CW'(N - 1)) begin
          sum_d   = {sum_bit, psum_q};
          cout_d  = cout_bit;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy = (state_q == ST_SHIFT);
  assign bus.done = (state_q == ST_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_sls_serial_adder_v.sv
module tb_sls_serial_adder_v;
  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  sls_serial_adder_v_if #(.N(8)) bus ();

  sls_serial_adder_v #(.N(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Launches one operation and watches it to completion (bounded).
  // Starts on a negedge where the block is idle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output int busy_cnt, output int done_cyc,
                        output logic [7:0] s, output logic c, output int hold_bad);
    logic [7:0] prev_sum;
    logic       prev_cout;
    @(negedge clk);
    prev_sum  = bus.sum;
    prev_cout = bus.cout;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    busy_cnt  = 0;
    done_cyc  = 0;
    hold_bad  = 0;
    s         = 8'hxx;
    c         = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        bus.cin   = ~cin;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cyc = i;
        s = bus.sum;
        c = bus.cout;
        break;
      end
      if (bus.sum !== prev_sum || bus.cout !== prev_cout) hold_bad++;
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    bus.cin   = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.sum !== 8'h00) begin n_err++; $display("FAIL reset_sum: got %h want 00", bus.sum); end
    n_cmp++; if (bus.cout !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %b want 0", bus.cout); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int busy_cnt, done_cyc, hold_bad;
    logic [7:0] s;
    logic c;
    run_op(8'h3C, 8'h42, 1'b0, busy_cnt, done_cyc, s, c, hold_bad);
    n_cmp++; if (busy_cnt != 8) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 8", busy_cnt); end
    n_cmp++; if (done_cyc != 9) begin n_err++; $display("FAIL basic_done_cycle: got %0d want 9", done_cyc); end
    n_cmp++; if (s !== 8'h7E) begin n_err++; $display("FAIL basic_sum: got %h want 7e", s); end
    n_cmp++; if (c !== 1'b0) begin n_err++; $display("FAIL basic_cout: got %b want 0", c); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL basic_done_width: got %b want 0", bus.done); end
    n_cmp++; if (bus.sum !== 8'h7E) begin n_err++; $display("FAIL basic_sum_hold_idle: got %h want 7e", bus.sum); end
  endtask

  task automatic test_sequence();
    logic [7:0] va [3] = '{8'hFF, 8'h5A, 8'h00};
    logic [7:0] vb [3] = '{8'h01, 8'hA5, 8'h00};
    logic       vc [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] es [3] = '{8'h00, 8'h00, 8'h00};
    logic       ec [3] = '{1'b1, 1'b1, 1'b0};
    int busy_cnt, done_cyc, hold_bad;
    logic [7:0] s;
    logic c;
    for (int k = 0; k < 3; k++) begin
      run_op(va[k], vb[k], vc[k], busy_cnt, done_cyc, s, c, hold_bad);
      n_cmp++; if (done_cyc != 9) begin n_err++; $display("FAIL seq%0d_done_cycle: got %0d want 9", k, done_cyc); end
      n_cmp++; if (s !== es[k]) begin n_err++; $display("FAIL seq%0d_sum: got %h want %h", k, s, es[k]); end
      n_cmp++; if (c !== ec[k]) begin n_err++; $display("FAIL seq%0d_cout: got %b want %b", k, c, ec[k]); end
      n_cmp++; if (hold_bad != 0) begin n_err++; $display("FAIL seq%0d_hold: %0d cycles changed, want 0", k, hold_bad); end
    end
  endtask

  task automatic test_ignore_start();
    int done_cnt, busy_cnt;
    logic [7:0] s;
    logic c;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0;
    done_cnt = 0; busy_cnt = 0; s = 8'hxx; c = 1'bx;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (i == 3) begin bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1; end
      if (i == 4) begin bus.start = 1'b0; bus.a = 8'h77; bus.b = 8'h11; end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin done_cnt++; s = bus.sum; c = bus.cout; end
    end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (busy_cnt != 8) begin n_err++; $display("FAIL ignore_busy_cycles: got %0d want 8", busy_cnt); end
    n_cmp++; if (s !== 8'h30) begin n_err++; $display("FAIL ignore_sum: got %h want 30", s); end
    n_cmp++; if (c !== 1'b0) begin n_err++; $display("FAIL ignore_cout: got %b want 0", c); end
  endtask

  task automatic test_reset_mid();
    int done_seen, busy_cnt, done_cyc, hold_bad;
    logic [7:0] s;
    logic c;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b1;
    done_seen = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (bus.done) done_seen++;
    end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before: got %b want 1", bus.busy); end
    n_cmp++; if (bus.sum !== 8'h30) begin n_err++; $display("FAIL rstmid_sum_before: got %h want 30", bus.sum); end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.sum !== 8'h00) begin n_err++; $display("FAIL rstmid_sum: got %h want 00", bus.sum); end
    n_cmp++; if (bus.cout !== 1'b0) begin n_err++; $display("FAIL rstmid_cout: got %b want 0", bus.cout); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    n_cmp++; if (done_seen != 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d activity cycles want 0", done_seen); end
    run_op(8'h01, 8'h01, 1'b0, busy_cnt, done_cyc, s, c, hold_bad);
    n_cmp++; if (done_cyc != 9) begin n_err++; $display("FAIL rstmid_after_done_cycle: got %0d want 9", done_cyc); end
    n_cmp++; if (s !== 8'h02) begin n_err++; $display("FAIL rstmid_after_sum: got %h want 02", s); end
    n_cmp++; if (c !== 1'b0) begin n_err++; $display("FAIL rstmid_after_cout: got %b want 0", c); end
  endtask

  task automatic test_back_to_back();
    int done_at [$];
    int prev_done;
    int wide;
    int bad_res;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h80; bus.b = 8'h80; bus.cin = 1'b0;
    prev_done = 0; wide = 0; bad_res = 0;
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      if (bus.done) begin
        done_at.push_back(i);
        if (prev_done) wide++;
        if (bus.sum !== 8'h00 || bus.cout !== 1'b1) bad_res++;
      end
      prev_done = bus.done;
    end
    bus.start = 1'b0;
    n_cmp++; if (done_at.size() != 3) begin n_err++; $display("FAIL b2b_done_count: got %0d want 3", done_at.size()); end
    if (done_at.size() >= 3) begin
      n_cmp++; if (done_at[0] != 9) begin n_err++; $display("FAIL b2b_first_done: got %0d want 9", done_at[0]); end
      n_cmp++; if (done_at[1] - done_at[0] != 10) begin n_err++; $display("FAIL b2b_period1: got %0d want 10", done_at[1] - done_at[0]); end
      n_cmp++; if (done_at[2] - done_at[1] != 10) begin n_err++; $display("FAIL b2b_period2: got %0d want 10", done_at[2] - done_at[1]); end
    end
    n_cmp++; if (wide != 0) begin n_err++; $display("FAIL b2b_done_width: got %0d wide pulses want 0", wide); end
    n_cmp++; if (bad_res != 0) begin n_err++; $display("FAIL b2b_result: got %0d bad results want 0", bad_res); end
    // Let the operation in flight drain before the next test.
    for (int i = 0; i < 15 && (bus.busy || bus.done); i++) @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL b2b_drain: busy got %b want 0", bus.busy); end
  endtask

  task automatic test_truth_table();
    // Expected {sum[1:0]} for index {cin,a0,b0}: 0,1,1,2,1,2,2,3
    logic [7:0] exp_sum [8] = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h01, 8'h02, 8'h02, 8'h03};
    int busy_cnt, done_cyc, hold_bad;
    logic [7:0] s;
    logic c;
    logic [2:0] v;
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      run_op({7'b0, v[1]}, {7'b0, v[0]}, v[2], busy_cnt, done_cyc, s, c, hold_bad);
      n_cmp++; if (s !== exp_sum[k]) begin n_err++; $display("FAIL fa%0d_sum: got %h want %h", k, s, exp_sum[k]); end
      n_cmp++; if (c !== 1'b0) begin n_err++; $display("FAIL fa%0d_cout: got %b want 0", k, c); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_sequence();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_truth_table();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
